// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-to-read bypass, destination select,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage_pipe #(
    parameter int DATA_W   = 16,
    parameter int CTRL_W   = 24,
    parameter int LINK_REG = 7,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [15:0]       id_instr,
    input  logic [15:0]       id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [1:0]        id_dst_sel,
    input  logic              id_wr_en,
    input  logic              id_mem_rd,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_ctrl_err,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_wr_en,
    input  logic [2:0]        wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [15:0]       ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [2:0]        ex_dst,
    output logic              ex_wr_en,
    output logic              ex_mem_rd,
    output logic              err,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [DATA_W-1:0] regFile [8];
    logic [2:0]        rsAddr, rtAddr, rdAddr, dstAddr;
    logic [2:0]        exRs, exRt;
    logic [DATA_W-1:0] rd1, rd2;
    logic              loadUse;
    logic              unusedInstrBits;

    assign rsAddr = id_instr[10:8];
    assign rtAddr = id_instr[7:5];
    assign rdAddr = id_instr[4:2];
    assign unusedInstrBits = ^{id_instr[15:11], id_instr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) regFile[i] <= '0;
        end else if (wb_wr_en) begin
            regFile[wb_wr_addr] <= wb_wr_data;
        end
    end

    always_comb begin
        rd1 = regFile[rsAddr];
        rd2 = regFile[rtAddr];
        if (BYPASS != 0 && wb_wr_en && wb_wr_addr == rsAddr) rd1 = wb_wr_data;
        if (BYPASS != 0 && wb_wr_en && wb_wr_addr == rtAddr) rd2 = wb_wr_data;
    end

    always_comb begin
        dstAddr = rtAddr;
        case (id_dst_sel)
            2'd0:    dstAddr = rtAddr;
            2'd1:    dstAddr = rsAddr;
            2'd2:    dstAddr = rdAddr;
            default: dstAddr = 3'(LINK_REG);
        endcase
    end

    assign loadUse = id_valid & ex_valid & ex_mem_rd & ex_wr_en &
                     ((id_rs_used & (rsAddr == ex_dst)) | (id_rt_used & (rtAddr == ex_dst)));
    assign id_stall = (loadUse | ex_stall) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_ctrl    <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_dst     <= '0;
            ex_wr_en   <= 1'b0;
            ex_mem_rd  <= 1'b0;
            exRs       <= '0;
            exRt       <= '0;
            err        <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_wr_en  <= 1'b0;
            ex_mem_rd <= 1'b0;
        end else if (ex_stall) begin
            // A held op keeps tracking writeback so it never leaves with stale operands.
            if (wb_wr_en && wb_wr_addr == exRs) ex_rd1 <= wb_wr_data;
            if (wb_wr_en && wb_wr_addr == exRt) ex_rd2 <= wb_wr_data;
        end else if (loadUse) begin
            ex_valid  <= 1'b0;
            ex_wr_en  <= 1'b0;
            ex_mem_rd <= 1'b0;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
        end else begin
            ex_valid  <= id_valid;
            ex_pc     <= id_pc;
            ex_ctrl   <= id_ctrl;
            ex_rd1    <= rd1;
            ex_rd2    <= rd2;
            ex_dst    <= dstAddr;
            ex_wr_en  <= id_wr_en & id_valid;
            ex_mem_rd <= id_mem_rd & id_valid;
            exRs      <= rsAddr;
            exRt      <= rtAddr;
            if (id_valid & id_ctrl_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: one instance with bypass and a wide
// bubble counter, one without bypass and with a 2-bit counter to reach saturation.
module tb_decode_stage_pipe;

    typedef struct {
        logic        v;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [1:0]  dsel;
        logic        we, mrd, rsu, rtu, cerr, xst, fl, wbe;
        logic [2:0]  wba;
        logic [15:0] wbd;
        logic        eStall, eValid, eWe, eMrd, eErr, chkData;
        logic [15:0] eCnt;
        logic [2:0]  eDst;
        logic [15:0] eRd1, eRd2, eRd1nb, eRd2nb, ePc;
    } vec_t;

    logic        clk, rst;
    logic        id_valid, id_wr_en, id_mem_rd, id_rs_used, id_rt_used, id_ctrl_err;
    logic [15:0] id_instr, id_pc;
    logic [23:0] id_ctrl;
    logic [1:0]  id_dst_sel;
    logic        ex_stall, flush, wb_wr_en;
    logic [2:0]  wb_wr_addr;
    logic [15:0] wb_wr_data;

    logic        id_stall, ex_valid, ex_wr_en, ex_mem_rd, err;
    logic [15:0] ex_pc, ex_rd1, ex_rd2, bubble_cnt;
    logic [23:0] ex_ctrl;
    logic [2:0]  ex_dst;

    logic        id_stall_nb, ex_valid_nb, ex_wr_en_nb, ex_mem_rd_nb, err_nb;
    logic [15:0] ex_pc_nb, ex_rd1_nb, ex_rd2_nb;
    logic [1:0]  bubble_cnt_nb;
    logic [23:0] ex_ctrl_nb;
    logic [2:0]  ex_dst_nb;

    int total = 0;
    int bad = 0;
    vec_t tv [18];

    decode_stage_pipe #(.DATA_W(16), .CTRL_W(24), .LINK_REG(7), .BYPASS(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .id_dst_sel(id_dst_sel), .id_wr_en(id_wr_en), .id_mem_rd(id_mem_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_ctrl_err(id_ctrl_err),
        .ex_stall(ex_stall), .flush(flush), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_wr_data(wb_wr_data), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_dst(ex_dst),
        .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .err(err), .bubble_cnt(bubble_cnt)
    );

    decode_stage_pipe #(.DATA_W(16), .CTRL_W(24), .LINK_REG(7), .BYPASS(0), .CNT_W(2)) dutNb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_ctrl(id_ctrl), .id_dst_sel(id_dst_sel), .id_wr_en(id_wr_en), .id_mem_rd(id_mem_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_ctrl_err(id_ctrl_err),
        .ex_stall(ex_stall), .flush(flush), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_wr_data(wb_wr_data), .id_stall(id_stall_nb), .ex_valid(ex_valid_nb), .ex_pc(ex_pc_nb),
        .ex_ctrl(ex_ctrl_nb), .ex_rd1(ex_rd1_nb), .ex_rd2(ex_rd2_nb), .ex_dst(ex_dst_nb),
        .ex_wr_en(ex_wr_en_nb), .ex_mem_rd(ex_mem_rd_nb), .err(err_nb), .bubble_cnt(bubble_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkIn(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                                  input logic [2:0] rd, input logic [1:0] dsel,
                                  input logic we, input logic mrd, input logic rsu, input logic rtu,
                                  input logic cerr, input logic xst, input logic fl,
                                  input logic wbe, input logic [2:0] wba, input logic [15:0] wbd,
                                  input logic [15:0] pc);
        vec_t t;
        t = '{default: '0};
        t.v = v; t.instr = {5'b0, rs, rt, rd, 2'b0}; t.pc = pc; t.dsel = dsel;
        t.we = we; t.mrd = mrd; t.rsu = rsu; t.rtu = rtu; t.cerr = cerr;
        t.xst = xst; t.fl = fl; t.wbe = wbe; t.wba = wba; t.wbd = wbd;
        return t;
    endfunction

    function automatic vec_t mkExp(input vec_t t, input logic st, input logic vld, input logic we,
                                   input logic mrd, input logic er, input logic [15:0] cnt,
                                   input logic chkD, input logic [2:0] dst,
                                   input logic [15:0] r1, input logic [15:0] r2,
                                   input logic [15:0] r1nb, input logic [15:0] r2nb,
                                   input logic [15:0] pc);
        vec_t o;
        o = t;
        o.eStall = st; o.eValid = vld; o.eWe = we; o.eMrd = mrd; o.eErr = er; o.eCnt = cnt;
        o.chkData = chkD; o.eDst = dst; o.eRd1 = r1; o.eRd2 = r2; o.eRd1nb = r1nb; o.eRd2nb = r2nb;
        o.ePc = pc;
        return o;
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v; id_instr = t.instr; id_pc = t.pc; id_ctrl = {8'hA5, t.pc};
        id_dst_sel = t.dsel; id_wr_en = t.we; id_mem_rd = t.mrd; id_rs_used = t.rsu;
        id_rt_used = t.rtu; id_ctrl_err = t.cerr; ex_stall = t.xst; flush = t.fl;
        wb_wr_en = t.wbe; wb_wr_addr = t.wba; wb_wr_data = t.wbd;
    endtask

    task automatic applyVec(input int idx, input vec_t t);
        logic [15:0] cntNb;
        cntNb = (t.eCnt > 16'd3) ? 16'd3 : t.eCnt;
        @(negedge clk);
        drive(t);
        #1;
        chk($sformatf("v%0d id_stall", idx), {31'b0, id_stall}, {31'b0, t.eStall});
        chk($sformatf("v%0d id_stall_nb", idx), {31'b0, id_stall_nb}, {31'b0, t.eStall});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ex_valid", idx), {31'b0, ex_valid}, {31'b0, t.eValid});
        chk($sformatf("v%0d ex_wr_en", idx), {31'b0, ex_wr_en}, {31'b0, t.eWe});
        chk($sformatf("v%0d ex_mem_rd", idx), {31'b0, ex_mem_rd}, {31'b0, t.eMrd});
        chk($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, t.eErr});
        chk($sformatf("v%0d err_nb", idx), {31'b0, err_nb}, {31'b0, t.eErr});
        chk($sformatf("v%0d bubble_cnt", idx), {16'b0, bubble_cnt}, {16'b0, t.eCnt});
        chk($sformatf("v%0d bubble_cnt_nb", idx), {30'b0, bubble_cnt_nb}, {16'b0, cntNb});
        if (t.chkData) begin
            chk($sformatf("v%0d ex_dst", idx), {29'b0, ex_dst}, {29'b0, t.eDst});
            chk($sformatf("v%0d ex_rd1", idx), {16'b0, ex_rd1}, {16'b0, t.eRd1});
            chk($sformatf("v%0d ex_rd2", idx), {16'b0, ex_rd2}, {16'b0, t.eRd2});
            chk($sformatf("v%0d ex_rd1_nb", idx), {16'b0, ex_rd1_nb}, {16'b0, t.eRd1nb});
            chk($sformatf("v%0d ex_rd2_nb", idx), {16'b0, ex_rd2_nb}, {16'b0, t.eRd2nb});
            chk($sformatf("v%0d ex_pc", idx), {16'b0, ex_pc}, {16'b0, t.ePc});
            chk($sformatf("v%0d ex_ctrl", idx), {8'b0, ex_ctrl}, {8'b0, 8'hA5, t.ePc});
        end
    endtask

    initial begin
        // v rs rt rd dsel we mrd rsu rtu cerr xst fl wbe wba wbd pc
        // -> stall valid we mrd err cnt chk dst rd1 rd2 rd1nb rd2nb pc
        tv[0]  = mkExp(mkIn(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,16'h0,16'h0100),
                       0,0,0,0,0,16'd0,0,0,16'h0,16'h0,16'h0,16'h0,16'h0);
        tv[1]  = mkExp(mkIn(1,1,2,3,2, 1,0,1,1,0, 0,0,0,0,16'h0,16'h0101),
                       0,1,1,0,0,16'd0,1,3,16'h0,16'h0,16'h0,16'h0,16'h0101);
        tv[2]  = mkExp(mkIn(1,1,4,0,0, 1,0,1,1,0, 0,0,1,1,16'h0011,16'h0102),
                       0,1,1,0,0,16'd0,1,4,16'h0011,16'h0,16'h0,16'h0,16'h0102);
        tv[3]  = mkExp(mkIn(1,3,1,0,1, 1,0,1,1,0, 0,0,1,3,16'h1234,16'h0103),
                       0,1,1,0,0,16'd0,1,3,16'h1234,16'h0011,16'h0,16'h0011,16'h0103);
        tv[4]  = mkExp(mkIn(1,1,2,0,0, 1,1,1,0,0, 0,0,0,0,16'h0,16'h0104),
                       0,1,1,1,0,16'd0,1,2,16'h0011,16'h0,16'h0011,16'h0,16'h0104);
        tv[5]  = mkExp(mkIn(1,2,3,5,2, 1,0,1,1,0, 0,0,0,0,16'h0,16'h0105),
                       1,0,0,0,0,16'd1,0,0,16'h0,16'h0,16'h0,16'h0,16'h0);
        tv[6]  = mkExp(mkIn(1,2,3,5,2, 1,0,1,1,0, 0,0,1,2,16'h0022,16'h0105),
                       0,1,1,0,0,16'd1,1,5,16'h0022,16'h1234,16'h0,16'h1234,16'h0105);
        tv[7]  = mkExp(mkIn(1,0,6,0,0, 1,1,1,0,0, 0,0,0,0,16'h0,16'h0107),
                       0,1,1,1,0,16'd1,1,6,16'h0,16'h0,16'h0,16'h0,16'h0107);
        tv[8]  = mkExp(mkIn(0,6,6,0,0, 1,1,1,1,1, 0,0,0,0,16'h0,16'h0108),
                       0,0,0,0,0,16'd1,0,0,16'h0,16'h0,16'h0,16'h0,16'h0);
        tv[9]  = mkExp(mkIn(1,4,5,1,2, 1,0,1,1,0, 0,0,0,0,16'h0,16'h0100),
                       0,1,1,0,0,16'd1,1,1,16'h0,16'h0,16'h0,16'h0,16'h0100);
        tv[10] = mkExp(mkIn(1,7,7,0,2, 0,0,1,1,0, 1,0,1,5,16'hBEEF,16'h0200),
                       1,1,1,0,0,16'd1,1,1,16'h0,16'hBEEF,16'h0,16'hBEEF,16'h0100);
        tv[11] = mkExp(mkIn(1,7,7,0,2, 0,0,1,1,0, 1,0,1,4,16'h4444,16'h0200),
                       1,1,1,0,0,16'd1,1,1,16'h4444,16'hBEEF,16'h4444,16'hBEEF,16'h0100);
        tv[12] = mkExp(mkIn(1,7,7,0,2, 0,0,1,1,0, 1,0,0,0,16'h0,16'h0200),
                       1,1,1,0,0,16'd1,1,1,16'h4444,16'hBEEF,16'h4444,16'hBEEF,16'h0100);
        tv[13] = mkExp(mkIn(1,7,5,0,2, 0,0,1,1,0, 0,0,0,0,16'h0,16'h0200),
                       0,1,0,0,0,16'd1,1,0,16'h0,16'hBEEF,16'h0,16'hBEEF,16'h0200);
        tv[14] = mkExp(mkIn(1,0,3,0,0, 1,1,1,0,0, 0,0,0,0,16'h0,16'h0114),
                       0,1,1,1,0,16'd1,1,3,16'h0,16'h1234,16'h0,16'h1234,16'h0114);
        tv[15] = mkExp(mkIn(1,3,0,2,2, 1,0,1,0,0, 1,1,0,0,16'h0,16'h0115),
                       0,0,0,0,0,16'd1,0,0,16'h0,16'h0,16'h0,16'h0,16'h0);
        tv[16] = mkExp(mkIn(1,2,1,0,3, 1,0,1,1,1, 0,0,0,0,16'h0,16'h0116),
                       0,1,1,0,1,16'd1,1,7,16'h0022,16'h0011,16'h0022,16'h0011,16'h0116);
        tv[17] = mkExp(mkIn(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,16'h0,16'h0117),
                       0,0,0,0,1,16'd1,0,0,16'h0,16'h0,16'h0,16'h0,16'h0);

        rst = 1'b1;
        drive(mkIn(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,16'h0,16'h0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
        chk("reset bubble_cnt", {16'b0, bubble_cnt}, 32'd0);
        chk("reset ex_wr_en", {31'b0, ex_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            logic [2:0] rs, rt;
            rs = 3'(r);
            rt = 3'(7 - r);
            @(negedge clk);
            drive(mkIn(1,rs,rt,0,2, 0,0,1,1,0, 0,0,0,0,16'h0,16'h0300));
            @(posedge clk);
            #1;
            chk($sformatf("rfzero rs=%0d ex_rd1", r), {16'b0, ex_rd1}, 32'd0);
            chk($sformatf("rfzero rt=%0d ex_rd2", r), {16'b0, ex_rd2}, 32'd0);
            chk($sformatf("rfzero %0d ex_valid", r), {31'b0, ex_valid}, 32'd1);
        end

        for (int i = 0; i < 18; i++) applyVec(i, tv[i]);

        // Repeated load-use pairs push the 2-bit counter into saturation.
        for (int k = 0; k < 4; k++) begin
            logic [15:0] expCnt, expCntNb;
            expCnt = 16'(2 + k);
            expCntNb = (expCnt > 16'd3) ? 16'd3 : expCnt;
            @(negedge clk);
            drive(mkIn(1,0,2,0,0, 1,1,1,0,0, 0,0,0,0,16'h0,16'h0400));
            @(negedge clk);
            drive(mkIn(1,2,0,1,2, 1,0,1,0,0, 0,0,0,0,16'h0,16'h0401));
            #1;
            chk($sformatf("sat%0d id_stall", k), {31'b0, id_stall}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d bubble_cnt", k), {16'b0, bubble_cnt}, {16'b0, expCnt});
            chk($sformatf("sat%0d bubble_cnt_nb", k), {30'b0, bubble_cnt_nb}, {16'b0, expCntNb});
            chk($sformatf("sat%0d bubble ex_valid", k), {31'b0, ex_valid}, 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("sat%0d released id_stall", k), {31'b0, id_stall}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d capture ex_dst", k), {29'b0, ex_dst}, 32'd1);
        end

        // Reset while a load-use stall is pending.
        @(negedge clk);
        drive(mkIn(1,0,2,0,0, 1,1,1,0,0, 0,0,0,0,16'h0,16'h0500));
        @(negedge clk);
        drive(mkIn(1,2,5,1,2, 1,0,1,1,0, 0,0,0,0,16'h0,16'h0501));
        #1;
        chk("rststall before id_stall", {31'b0, id_stall}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rststall id_stall", {31'b0, id_stall}, 32'd0);
        chk("rststall ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rststall err", {31'b0, err}, 32'd0);
        chk("rststall bubble_cnt", {16'b0, bubble_cnt}, 32'd0);
        chk("rststall bubble_cnt_nb", {30'b0, bubble_cnt_nb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset rf ex_rd1", {16'b0, ex_rd1}, 32'd0);
        chk("post-reset rf ex_rd2", {16'b0, ex_rd2}, 32'd0);
        chk("post-reset ex_valid", {31'b0, ex_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
